// File: rtl/sriov_pkg.sv
// sriov_pkg: shared SR-IOV capability constants, register offsets and VF FSM state type
package sriov_pkg;
  typedef enum logic [1:0] {ST_DISABLED, ST_ENABLING, ST_ENABLED, ST_DISABLING} vf_state_e;
  localparam logic [11:0] OFF_HDR  = 12'h000;
  localparam logic [11:0] OFF_CAP  = 12'h004;
  localparam logic [11:0] OFF_CTRL = 12'h008;
  localparam logic [11:0] OFF_VFS  = 12'h00C;
  localparam logic [11:0] OFF_NUM  = 12'h010;
  localparam logic [11:0] OFF_RID  = 12'h014;
  localparam logic [15:0] SRIOV_CAP_ID  = 16'h0010;
  localparam logic [3:0]  SRIOV_CAP_VER = 4'h1;
endpackage

// File: rtl/sriov_vf_enable_fsm.sv
// sriov_vf_enable_fsm: VF Enable settle sequencer; a bit0 flip mid-transition reverses direction
module sriov_vf_enable_fsm
  import sriov_pkg::*;
#(
  parameter int SETTLE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vf_en,
  input  logic [15:0] i_num_vfs,
  output logic        o_busy,
  output logic        o_enabled,
  output logic [15:0] o_num_vfs_active
);
  localparam int CW = $clog2(SETTLE);
  localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);
  vf_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_num_active;
  logic w_load, w_cnt_zero;
  assign w_cnt_zero = r_cnt == '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_DISABLED: w_next = i_vf_en ? ST_ENABLING : ST_DISABLED;
      ST_ENABLING: w_next = !i_vf_en ? ST_DISABLING : (w_cnt_zero ? ST_ENABLED : ST_ENABLING);
      ST_ENABLED:  w_next = i_vf_en ? ST_ENABLED : ST_DISABLING;
      default:     w_next = i_vf_en ? ST_ENABLING : (w_cnt_zero ? ST_DISABLED : ST_DISABLING);
    endcase
  end
  assign w_load = (w_next == ST_ENABLING || w_next == ST_DISABLING) && w_next != r_state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_DISABLED;
      r_cnt        <= '0;
      r_num_active <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_load ? LOAD : (w_cnt_zero ? r_cnt : r_cnt - CW'(1));
      if (w_next == ST_ENABLING && r_state != ST_ENABLING)
        r_num_active <= i_num_vfs;
      else if (w_next == ST_DISABLED && r_state != ST_DISABLED)
        r_num_active <= '0;
    end
  end
  assign o_busy           = r_state == ST_ENABLING || r_state == ST_DISABLING;
  assign o_enabled        = r_state == ST_ENABLED;
  assign o_num_vfs_active = r_num_active;
endmodule

// File: rtl/sriov_ctrl_regs.sv
// sriov_ctrl_regs: SR-IOV extended capability register block with VF Enable sequencing
module sriov_ctrl_regs
  import sriov_pkg::*;
#(
  parameter logic [11:0] CAP_BASE         = 12'h160,
  parameter logic [11:0] NEXT_CAP_PTR     = 12'h000,
  parameter int          TOTAL_VFS        = 16,
  parameter int          INITIAL_VFS      = 16,
  parameter logic [15:0] FIRST_VF_OFFSET  = 16'd1,
  parameter logic [15:0] VF_STRIDE        = 16'd1,
  parameter int          VF_SETTLE_CYCLES = 1024,
  parameter bit          VF_10BIT_TAG_SUP = 1'b0,
  parameter bit          VF_14BIT_TAG_SUP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cfg_addr,
  input  logic        cfg_wr_en,
  input  logic [3:0]  cfg_wr_be,
  input  logic [31:0] cfg_wr_data,
  input  logic        cfg_rd_en,
  output logic [31:0] cfg_rd_data,
  output logic        cfg_rd_valid,
  input  logic        dev_cap2_10bit_tag_supported,
  input  logic        dev_cap2_14bit_tag_supported,
  output logic        vf_enabled,
  output logic        vf_busy,
  output logic [15:0] num_vfs_active,
  output logic        vf_mse,
  output logic        vf_10bit_tag_req_en,
  output logic        ari_capable_hier
);
  logic [11:0] w_off;
  logic w_tag10_cap, w_tag14_cap, w_wr_ctrl, w_wr_num;
  logic r_vf_en, r_mse, r_ari, r_tag10, r_rd_valid;
  logic [15:0] r_num_vfs;
  logic [31:0] w_ctrl, w_rd_mux, r_rd_data;
  assign w_off       = cfg_addr - CAP_BASE;
  assign w_tag10_cap = VF_10BIT_TAG_SUP & dev_cap2_10bit_tag_supported;
  assign w_tag14_cap = VF_14BIT_TAG_SUP & dev_cap2_14bit_tag_supported;
  assign w_ctrl      = {26'b0, r_tag10 & w_tag10_cap, r_ari, r_mse, 2'b0, r_vf_en};
  always_comb
    w_rd_mux = w_off == OFF_HDR  ? {NEXT_CAP_PTR, SRIOV_CAP_VER, SRIOV_CAP_ID} :
               w_off == OFF_CAP  ? {28'b0, w_tag14_cap, w_tag10_cap, 2'b0} :
               w_off == OFF_CTRL ? w_ctrl :
               w_off == OFF_VFS  ? {16'(TOTAL_VFS), 16'(INITIAL_VFS)} :
               w_off == OFF_NUM  ? {16'b0, r_num_vfs} :
               w_off == OFF_RID  ? {VF_STRIDE, FIRST_VF_OFFSET} : '0;
  assign w_wr_ctrl = cfg_wr_en && w_off == OFF_CTRL && cfg_wr_be[0];
  // NumVFs is frozen while VFs are enabled or settling, and over-range values are dropped
  assign w_wr_num  = cfg_wr_en && w_off == OFF_NUM && &cfg_wr_be[1:0] && !r_vf_en && !vf_busy &&
                     {1'b0, cfg_wr_data[15:0]} <= 17'(TOTAL_VFS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vf_en    <= 1'b0;
      r_mse      <= 1'b0;
      r_ari      <= 1'b0;
      r_tag10    <= 1'b0;
      r_num_vfs  <= 16'(INITIAL_VFS);
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_vf_en <= cfg_wr_data[0];
        r_mse   <= cfg_wr_data[3];
        r_tag10 <= cfg_wr_data[5] & w_tag10_cap;
        if (!r_vf_en) r_ari <= cfg_wr_data[4];
      end
      if (w_wr_num) r_num_vfs <= cfg_wr_data[15:0];
      r_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) r_rd_data <= w_rd_mux;
    end
  end
  sriov_vf_enable_fsm #(.SETTLE(VF_SETTLE_CYCLES)) u_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vf_en         (r_vf_en),
    .i_num_vfs       (r_num_vfs),
    .o_busy          (vf_busy),
    .o_enabled       (vf_enabled),
    .o_num_vfs_active(num_vfs_active)
  );
  assign cfg_rd_data         = r_rd_data;
  assign cfg_rd_valid        = r_rd_valid;
  assign vf_mse              = r_mse & vf_enabled;
  assign vf_10bit_tag_req_en = w_ctrl[5];
  assign ari_capable_hier    = r_ari;
endmodule

// File: doc/sriov_ctrl_regs.md
SRIOV_CTRL_REGS -- requirements
Module: sriov_ctrl_regs

Interface
REQ-001 SHALL have parameter CAP_BASE, default 12'h160, meaning config-space byte offset of the SR-IOV Extended Capability header.
REQ-002 SHALL have parameter NEXT_CAP_PTR, default 12'h000, meaning the header Next Capability Offset.
REQ-003 SHALL have parameter TOTAL_VFS, default 16, meaning the TotalVFs value, range 1..256.
REQ-004 SHALL have parameter INITIAL_VFS, default 16, meaning the InitialVFs value, at most TOTAL_VFS.
REQ-005 SHALL have parameters FIRST_VF_OFFSET, default 1, and VF_STRIDE, default 1, both 16-bit RO field values.
REQ-006 SHALL have parameter VF_SETTLE_CYCLES, default 1024, meaning VF Enable transition time in clk cycles, at least 2.
REQ-007 SHALL have parameters VF_10BIT_TAG_SUP and VF_14BIT_TAG_SUP, default 0, meaning the HwInit tag-support capability bits.
REQ-008 SHALL have ports: clk in 1, clock; rst_n in 1, reset.
REQ-009 SHALL have ports: cfg_addr in 12, DW-aligned byte address; cfg_wr_en in 1; cfg_wr_be in 4; cfg_wr_data in 32; cfg_rd_en in 1.
REQ-010 SHALL have ports: cfg_rd_data out 32; cfg_rd_valid out 1.
REQ-011 SHALL have ports: dev_cap2_10bit_tag_supported in 1; dev_cap2_14bit_tag_supported in 1.
REQ-012 SHALL have ports: vf_enabled out 1; vf_busy out 1; num_vfs_active out 16; vf_mse out 1; vf_10bit_tag_req_en out 1; ari_capable_hier out 1.
REQ-013 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-014 Register map relative to CAP_BASE SHALL be:
- +0x00: header (ID 16'h0010, version 4'h1, NEXT_CAP_PTR)
- +0x04: capabilities
- +0x08: control[15:0] and status[31:16]
- +0x0C: InitialVFs[15:0] and TotalVFs[31:16]
- +0x10: NumVFs[15:0] and Function Dependency Link[23:16]=0
- +0x14: FirstVFOffset[15:0] and VFStride[31:16]
Other addresses SHALL read as 0 and ignore writes.
REQ-015 Capabilities SHALL read as follows:
- bit0 = 0, bit1 = 0, [31:21] = 0
- bit2 = VF_10BIT_TAG_SUP AND dev_cap2_10bit_tag_supported
- bit3 = VF_14BIT_TAG_SUP AND dev_cap2_14bit_tag_supported
REQ-016 Control bits SHALL be:
- bit0 VF Enable (RW)
- bit3 VF MSE (RW)
- bit4 ARI Capable Hierarchy (RW)
- bit5 VF 10-Bit Tag Requester Enable: RW when capability bit2 = 1, else hardwired 0
- all other bits read 0
REQ-017 Status SHALL read 0; the RW1C migration bit is hardwired 0.
REQ-018 Writes SHALL honour cfg_wr_be per byte; NumVFs bits only update when both bytes 0 and 1 are enabled.
REQ-019 A NumVFs write SHALL be ignored when control bit0 = 1, vf_busy = 1, or the value > TOTAL_VFS.
REQ-020 A write to bit4 SHALL be ignored while control bit0 = 1.
REQ-021 Reads SHALL be registered: cfg_rd_valid pulses 1 cycle after cfg_rd_en, and cfg_rd_data holds until the next read.
REQ-022 A simultaneous read and write to the same address SHALL return pre-write data.
REQ-023 The VF FSM SHALL have states DISABLED, ENABLING, ENABLED and DISABLING, with a settle counter.
REQ-024 FSM transitions SHALL be:
- DISABLED to ENABLING on control bit0 0→1, loading the counter with VF_SETTLE_CYCLES-1
- ENABLING to ENABLED when the counter reaches 0
- ENABLED to DISABLING on bit0 1→0
- DISABLING to DISABLED when the counter reaches 0
REQ-025 If bit0 flips during ENABLING or DISABLING, the FSM SHALL enter the opposite transition state and reload the counter.
REQ-026 vf_busy SHALL be 1 in ENABLING and DISABLING.
REQ-027 vf_enabled SHALL be 1 only in ENABLED.
REQ-028 num_vfs_active SHALL latch NumVFs on entry to ENABLING and clear to 0 on entry to DISABLED.
REQ-029 Enabling with NumVFs = 0 SHALL complete normally, and num_vfs_active SHALL be 0.
REQ-030 vf_mse SHALL equal control bit3 AND vf_enabled; vf_10bit_tag_req_en SHALL equal control bit5; ari_capable_hier SHALL equal control bit4.

Reset
REQ-031 On rst_n low the block SHALL set control = 0, NumVFs = INITIAL_VFS, FSM = DISABLED, counter = 0, cfg_rd_data = 0, cfg_rd_valid = 0, and all outputs 0.
REQ-032 Reset asserted mid-transition SHALL abort immediately to DISABLED with no settle delay.

Structure
REQ-033 Package sriov_pkg SHALL hold the FSM state enum, register offset localparams, the capability ID and the version constant.
REQ-034 Settle counter plus FSM SHALL be a sub-module sriov_vf_enable_fsm.

Verification
REQ-035 Reset, then read +0x0C → 32'h0010_0010; read +0x10 → 32'h0000_0010; read +0x00 → 32'h0001_0010.
REQ-036 Write NumVFs = 8, then set VF Enable → vf_busy = 1 for exactly VF_SETTLE_CYCLES cycles, then vf_enabled = 1 and num_vfs_active = 8.
REQ-037 While ENABLED, write NumVFs = 4 → readback stays 8; write NumVFs = 17 while disabled → readback unchanged.
REQ-038 Clear VF Enable halfway through ENABLING → FSM enters DISABLING, counter reloads, and vf_enabled never asserts.
REQ-039 VF_10BIT_TAG_SUP = 1 with dev_cap2_10bit_tag_supported = 0 → capability bit2 reads 0 and a write to control bit5 reads back 0.
REQ-040 Assert rst_n low during ENABLED with vf_mse = 1 → all outputs 0 asynchronously, and NumVFs reads back INITIAL_VFS.
